// File: rtl/uart_rx.sv
// UART receiver: synchronises the RX pin, validates the start bit, samples data and
// stop bits at mid-bit (LSB first) and reports each frame as a one-cycle pulse.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break,
    output logic [1:0]              o_dbg_state
);

    localparam int CPB  = (1_000_000_000 / BIT_RATE) / (1_000_000_000 / CLK_HZ);
    localparam int HALF = CPB / 2;
    localparam int CW   = 1 + $clog2(CPB);
    localparam int BMAX = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int BCW  = 1 + $clog2(BMAX);

    localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]  CPB_M1  = CW'(CPB - 1);
    localparam logic [BCW-1:0] PB_LAST = BCW'(PAYLOAD_BITS - 1);
    localparam logic [BCW-1:0] SB_LAST = BCW'(STOP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RECV, S_STOP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_rxd_meta;
    logic                    r_rxd_s;
    logic                    r_rxd_d;
    logic [CW-1:0]           r_cycle_cnt;
    logic [BCW-1:0]          r_bit_cnt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_err;
    logic                    w_fall;
    logic                    w_sample;
    logic                    w_done;
    logic                    w_err_now;
    logic                    w_enter;

    assign w_fall      = r_rxd_d & ~r_rxd_s;
    assign w_enter     = (w_next != r_state);
    assign o_dbg_state = r_state;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_d    <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_d    <= r_rxd_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall && uart_rx_en) w_next = S_START;
            S_START: if (w_sample) w_next = r_rxd_s ? S_IDLE : S_RECV;
            S_RECV:  if (w_sample && (r_bit_cnt == PB_LAST)) w_next = S_STOP;
            S_STOP:  if (w_sample && (r_bit_cnt == SB_LAST)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sample = 1'b0;
        case (r_state)
            S_START:        w_sample = (r_cycle_cnt == HALF_M1);
            S_RECV, S_STOP: w_sample = (r_cycle_cnt == CPB_M1);
            default:        w_sample = 1'b0;
        endcase
        w_done    = (r_state == S_STOP) && w_sample && (r_bit_cnt == SB_LAST);
        w_err_now = r_err | ~r_rxd_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if (w_enter || w_sample)  r_cycle_cnt <= '0;
            else if (r_state != S_IDLE) r_cycle_cnt <= r_cycle_cnt + CW'(1);

            if (w_enter) r_bit_cnt <= '0;
            else if (w_sample && ((r_state == S_RECV) || (r_state == S_STOP)))
                r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
    end

    // Right shift puts the first (LSB) bit in position 0 once all bits are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == S_RECV) && w_sample)
                r_shift <= {r_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
            if (w_enter && (w_next == S_START))
                r_err <= 1'b0;
            else if ((r_state == S_STOP) && w_sample && !r_rxd_s)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            uart_rx_data      <= '0;
        end else begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            if (w_done) begin
                if (!w_err_now) begin
                    uart_rx_valid <= 1'b1;
                    uart_rx_data  <= r_shift;
                end else begin
                    uart_rx_frame_err <= 1'b1;
                    uart_rx_break     <= (r_shift == '0) && !r_rxd_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CPB=10: scenario tasks drive serial frames, push expected
// events {valid, frame_err, break, data}, and compare them with the observed pulses.
module tb_uart_rx;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic       en    = 1'b1;
    logic       valid;
    logic       ferr;
    logic       brk;
    logic [7:0] data;
    logic [1:0] dbg_state;

    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int          obs_cyc_q[$];
    int          cyc       = 0;
    int          n_cmp     = 0;
    int          n_fail    = 0;
    logic [7:0]  last_data = 8'h00;

    uart_rx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .uart_rxd         (rxd),
        .uart_rx_en       (en),
        .uart_rx_valid    (valid),
        .uart_rx_data     (data),
        .uart_rx_frame_err(ferr),
        .uart_rx_break    (brk),
        .o_dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every output pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (!reset && (valid || ferr || brk)) begin
            obs_q.push_back({valid, ferr, brk, data});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rxd = stop_v;
        hold(CPB);
        rxd = 1'b1;
    endtask

    task automatic expect_good(input logic [7:0] b);
        exp_q.push_back({3'b100, b});
        last_data = b;
    endtask

    task automatic expect_err(input logic brk_v);
        exp_q.push_back({2'b01, brk_v, last_data});
    endtask

    task automatic test_reset;
        reset = 1'b1;
        hold(3);
        n_cmp++;
        if ({valid, ferr, brk, data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_held_outputs: got %h want 000", {valid, ferr, brk, data});
        end
        reset = 1'b0;
        hold(30);
        n_cmp++;
        if ({valid, ferr, brk, data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: got %h want 000", {valid, ferr, brk, data});
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d pulses want 0", obs_q.size());
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_basic;
        logic [10:0] e, o;
        int t0;
        t0 = cyc;
        expect_good(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold(10);
        // pin fall -> START after 3 edges, last stop sample 95 edges later
        n_cmp++;
        if (obs_cyc_q.size() == 0 || (obs_cyc_q[0] - t0) != 98) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 98",
                     (obs_cyc_q.size() == 0) ? -1 : obs_cyc_q[0] - t0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        hold(30);
        n_cmp++;
        if (data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data_held: got %h want a5", data);
        end
    endtask

    task automatic test_stop_err;
        logic [10:0] e, o;
        expect_err(1'b0);
        send_frame(8'h3C, 1'b0);
        hold(10);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stop_err_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stop_err_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_cmp++;
        if (data !== 8'hA5) begin
            n_fail++;
            $display("FAIL stop_err_data_kept: got %h want a5", data);
        end
    endtask

    task automatic test_glitch;
        logic [10:0] e, o;
        rxd = 1'b0;
        hold(3);
        rxd = 1'b1;
        hold(30);
        n_cmp++;
        if (obs_q.size() != 0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got %0d pulses state %0d want 0 pulses state 0",
                     obs_q.size(), dbg_state);
        end
        obs_q.delete(); obs_cyc_q.delete();
        expect_good(8'h5A);
        send_frame(8'h5A, 1'b1);
        hold(10);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL glitch_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_break;
        logic [10:0] e, o;
        expect_err(1'b1);
        rxd = 1'b0;
        hold(12 * CPB);
        rxd = 1'b1;
        hold(40);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL break_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL break_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        expect_good(8'h81);
        send_frame(8'h81, 1'b1);
        hold(10);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL break_recover_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL break_recover_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [10:0] e, o;
        expect_good(8'h00);
        expect_good(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(10);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [10:0] e, o;
        logic [7:0]  b;
        b   = 8'h5A;
        en  = 1'b1;
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rxd = b[4];
        hold(5);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({valid, ferr, brk, data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h want 000", {valid, ferr, brk, data});
        end
        en = 1'b0;
        hold(3);
        reset     = 1'b0;
        last_data = 8'h00;
        hold(2);
        for (int i = 5; i < 8; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rxd = 1'b1;
        hold(CPB);
        hold(20);
        send_frame(8'h99, 1'b1);
        hold(20);
        n_cmp++;
        if (obs_q.size() != 0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_disabled: got %0d pulses data %h want 0 pulses data 00",
                     obs_q.size(), data);
        end
        obs_q.delete(); obs_cyc_q.delete();
        en = 1'b1;
        hold(5);
        expect_good(8'h42);
        send_frame(8'h42, 1'b1);
        hold(10);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_event: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_err();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
